// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDRESS_WIDTH = 12;
    localparam int ARB_WIDTH         = 32;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // One granted access waiting to drive the ram in the next cycle.
    typedef struct packed {
        logic                         valid;
        logic                         owner;
        logic                         we;
        logic [ARB_ADDRESS_WIDTH-1:0] addr;
        logic [ARB_WIDTH-1:0]         wdata;
    } issue_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side requesters plus ram-side port of the memory arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int WIDTH         = 32
);
    logic                     i_req;
    logic [ADDRESS_WIDTH-1:0] i_addr;
    logic                     i_gnt;
    logic                     i_rvalid;
    logic [WIDTH-1:0]         i_rdata;

    logic                     d_req;
    logic                     d_we;
    logic [ADDRESS_WIDTH-1:0] d_addr;
    logic [WIDTH-1:0]         d_wdata;
    logic                     d_gnt;
    logic                     d_rvalid;
    logic [WIDTH-1:0]         d_rdata;

    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_read_addr;
    logic [ADDRESS_WIDTH-1:0] ram_write_addr;
    logic [WIDTH-1:0]         ram_wdata;
    logic [WIDTH-1:0]         ram_rdata;

    // Core and ram side (drives requests and ram read data).
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_we, ram_read_addr, ram_write_addr, ram_wdata
    );

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_we, ram_read_addr, ram_write_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select: D by default, I when alone or starved.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic starve,
    output logic i_gnt,
    output logic d_gnt,
    output logic owner
);

    // Single grant per cycle, only to a requester that is asking.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        owner = OWNER_D;
        if (i_req && (!d_req || starve)) begin
            i_gnt = 1'b1;
            owner = OWNER_I;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ram between instruction fetch (I) and load/store (D):
// arbitrate in N, drive ram in N+1, return data in N+2.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 12,
    parameter int WIDTH         = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    logic [3:0]               starve_cnt;
    logic                     starve;
    logic                     i_gnt_w;
    logic                     d_gnt_w;
    logic                     owner_w;
    logic                     any_gnt;
    logic [ADDRESS_WIDTH-1:0] win_addr;

    issue_t                   iss;

    logic                     resp_valid;
    logic                     resp_owner;
    logic [WIDTH-1:0]         i_rdata_q;
    logic [WIDTH-1:0]         d_rdata_q;

    assign starve = (starve_cnt == 4'(STARVE_LIMIT));

    // Requests are masked while in reset so no grant can be issued.
    mem_arb_pick u_pick (
        .i_req  (bus.i_req & rst),
        .d_req  (bus.d_req & rst),
        .starve (starve),
        .i_gnt  (i_gnt_w),
        .d_gnt  (d_gnt_w),
        .owner  (owner_w)
    );

    assign any_gnt   = i_gnt_w | d_gnt_w;
    assign win_addr  = d_gnt_w ? bus.d_addr : bus.i_addr;
    assign bus.i_gnt = i_gnt_w;
    assign bus.d_gnt = d_gnt_w;

    // Count consecutive refused I cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!bus.i_req || i_gnt_w) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Issue stage: capture the winner; payload holds across idle cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            iss.valid <= 1'b0;
        end else begin
            iss.valid <= any_gnt;
            if (any_gnt) begin
                iss.owner <= owner_w;
                iss.we    <= d_gnt_w & bus.d_we;
                iss.addr  <= win_addr;
                iss.wdata <= bus.d_wdata;
            end
        end
    end

    assign bus.ram_we         = iss.valid & iss.we;
    assign bus.ram_read_addr  = iss.addr;
    assign bus.ram_write_addr = iss.addr;
    assign bus.ram_wdata      = iss.wdata;

    // Response stage: per-owner data registers so each rdata holds its last value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            resp_valid <= iss.valid;
            resp_owner <= iss.owner;
            if (iss.valid) begin
                if (iss.owner == OWNER_I) begin
                    i_rdata_q <= iss.we ? '0 : bus.ram_rdata;
                end else begin
                    d_rdata_q <= iss.we ? '0 : bus.ram_rdata;
                end
            end
        end
    end

    assign bus.i_rvalid = resp_valid & (resp_owner == OWNER_I);
    assign bus.d_rvalid = resp_valid & (resp_owner == OWNER_D);
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural ram model.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDRESS_WIDTH(12), .WIDTH(32)) bus();

    mem_port_arbiter #(
        .ADDRESS_WIDTH (12),
        .WIDTH         (32),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ram: combinational word read, registered write.
    assign bus.ram_rdata = mem[bus.ram_read_addr[11:2]];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_write_addr[11:2]] <= bus.ram_wdata;
    end

    typedef struct {
        logic        ir;
        logic [11:0] ia;
        logic        dr;
        logic        dw;
        logic [11:0] da;
        logic [31:0] dd;
        logic        eig;
        logic        edg;
        logic        ewe;
        logic        eiv;
        logic [31:0] eird;
        logic        edv;
        logic [31:0] edrd;
        logic        ca;
        logic [11:0] ea;
    } vec_t;

    vec_t vt[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t v(
        input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
        input logic [11:0] da, input logic [31:0] dd,
        input logic eig, input logic edg, input logic ewe,
        input logic eiv, input logic [31:0] eird,
        input logic edv, input logic [31:0] edrd,
        input logic ca, input logic [11:0] ea);
        vec_t r;
        r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.eig = eig; r.edg = edg; r.ewe = ewe;
        r.eiv = eiv; r.eird = eird; r.edv = edv; r.edrd = edrd;
        r.ca = ca; r.ea = ea;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [11:0] ia, input logic dr,
                         input logic dw, input logic [11:0] da, input logic [31:0] dd);
        bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = 32'h00000013;
        mem[1]  = 32'h00A00093;
        mem[4]  = 32'hDEADBEEF;
        mem[12] = 32'hCAFEF00D;

        // Single D read, write-then-read, single I, interleaved I/D, contention.
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,1,0,12'h010,32'h0,         0,1,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        0,32'h0,        1,12'h010));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        1,32'hDEADBEEF, 0,12'h000));
        vt.push_back(v(0,12'h000,1,1,12'h020,32'h12345678,  0,1,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,1,0,12'h020,32'h0,         0,1,1, 0,32'h0,        0,32'h0,        1,12'h020));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        1,32'h0,        1,12'h020));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        1,32'h12345678, 0,12'h000));
        vt.push_back(v(1,12'h000,0,0,12'h000,32'h0,         1,0,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 1,32'h00000013, 0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        0,32'h0,        0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         1,0,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 1,32'h00000013, 0,32'h0,        0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         0,1,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(1,12'h000,1,0,12'h004,32'h0,         1,0,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        1,32'h00A00093, 0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 1,32'h00000013, 0,32'h0,        0,12'h000));
        vt.push_back(v(0,12'h000,0,0,12'h000,32'h0,         0,0,0, 0,32'h0,        0,32'h0,        0,12'h000));

        // Initial reset
        rst = 1'b0;
        drive(0, 12'h000, 0, 0, 12'h000, 32'h0);
        step();
        step();
        #2;
        chk("reset i_rvalid", 32'(bus.i_rvalid), 32'h0);
        chk("reset d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("reset ram_we",   32'(bus.ram_we),   32'h0);
        chk("reset i_rdata",  bus.i_rdata,       32'h0);
        chk("reset d_rdata",  bus.d_rdata,       32'h0);
        rst = 1'b1;
        step();

        for (int r = 0; r < vt.size(); r++) begin
            drive(vt[r].ir, vt[r].ia, vt[r].dr, vt[r].dw, vt[r].da, vt[r].dd);
            #2;
            chk($sformatf("row%0d i_gnt", r),    32'(bus.i_gnt),    32'(vt[r].eig));
            chk($sformatf("row%0d d_gnt", r),    32'(bus.d_gnt),    32'(vt[r].edg));
            chk($sformatf("row%0d ram_we", r),   32'(bus.ram_we),   32'(vt[r].ewe));
            chk($sformatf("row%0d i_rvalid", r), 32'(bus.i_rvalid), 32'(vt[r].eiv));
            chk($sformatf("row%0d d_rvalid", r), 32'(bus.d_rvalid), 32'(vt[r].edv));
            if (vt[r].eiv) chk($sformatf("row%0d i_rdata", r), bus.i_rdata, vt[r].eird);
            if (vt[r].edv) chk($sformatf("row%0d d_rdata", r), bus.d_rdata, vt[r].edrd);
            if (vt[r].ca)  chk($sformatf("row%0d ram_addr", r), 32'(bus.ram_read_addr), 32'(vt[r].ea));
            step();
        end

        // Reset lands while a D write sits in the issue stage
        drive(0, 12'h000, 1, 1, 12'h030, 32'h11111111);
        #2;
        chk("midrst d_gnt", 32'(bus.d_gnt), 32'h1);
        rst = 1'b0;
        step();
        drive(0, 12'h000, 0, 0, 12'h000, 32'h0);
        #2;
        chk("midrst ram_we",  32'(bus.ram_we), 32'h0);
        chk("midrst i_rdata", bus.i_rdata,     32'h0);
        chk("midrst d_rdata", bus.d_rdata,     32'h0);
        rst = 1'b1;
        step();
        chk("midrst mem12", mem[12], 32'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("midrst d_rvalid c%0d", k), 32'(bus.d_rvalid), 32'h0);
            chk($sformatf("midrst i_rvalid c%0d", k), 32'(bus.i_rvalid), 32'h0);
            step();
        end

        // Both requesting while held in reset: no grants, then D first
        rst = 1'b0;
        drive(1, 12'h000, 1, 0, 12'h004, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("hold i_gnt c%0d", k), 32'(bus.i_gnt), 32'h0);
            chk($sformatf("hold d_gnt c%0d", k), 32'(bus.d_gnt), 32'h0);
            step();
        end
        rst = 1'b1;
        #2;
        chk("release d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("release i_gnt", 32'(bus.i_gnt), 32'h0);
        step();
        drive(0, 12'h000, 0, 0, 12'h000, 32'h0);
        step();
        #2;
        chk("release d_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("release d_rdata",  bus.d_rdata,       32'h00A00093);
        chk("release i_rvalid", 32'(bus.i_rvalid), 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single ram instance (one read port, one write port, combinational read, registered write) between the core's instruction-fetch requester (I) and load/store requester (D).
- Sits between the core and ram. Arbitrates one access per cycle, registers the winner into one issue stage, and returns read data to the winner two cycles after grant.
- D wins by default. A starvation counter forces an I grant after a bounded wait.

Parameters:
- ADDRESS_WIDTH, 12, byte address width; matches ram ADDRESS_WIDTH.
- WIDTH, 32, data word width; matches ram WIDTH.
- STARVE_LIMIT, 4, consecutive cycles I may be pending and refused before I is forced to win; range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low: asserted when 0, sampled on posedge clk.
- i_req  in  1  I request; held with i_addr stable until i_gnt.
- i_addr  in  ADDRESS_WIDTH  I byte address; read-only requester.
- i_gnt  out  1  I request accepted this cycle (combinational).
- i_rvalid  out  1  I read data valid, one-cycle pulse.
- i_rdata  out  WIDTH  I read data; valid only with i_rvalid.
- d_req  in  1  D request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDRESS_WIDTH  D byte address.
- d_wdata  in  WIDTH  D write data.
- d_gnt  out  1  D request accepted this cycle (combinational).
- d_rvalid  out  1  D completion pulse, for reads and writes.
- d_rdata  out  WIDTH  D read data; 0 on write completions.
- ram_we  out  1  to ram write_enable.
- ram_read_addr  out  ADDRESS_WIDTH  to ram read_addr.
- ram_write_addr  out  ADDRESS_WIDTH  to ram write_addr; same value as ram_read_addr.
- ram_wdata  out  WIDTH  to ram data_in.
- ram_rdata  in  WIDTH  from ram data_out.

Behaviour:
- Pipeline per request:
  - Cycle N: arbitration; gnt to the winner.
  - End of N: issue stage captures {valid, owner, we, addr, wdata}.
  - Cycle N+1: the issue stage drives the ram. ram_we = stage valid & we. End of N+1: response register captures ram_rdata (0 if we), owner, valid.
  - Cycle N+2: x_rvalid pulses for the owner; x_rdata = captured data.
- Throughput: one grant per cycle. Back-to-back grants are allowed, including a D write followed by a read of the same address. The write commits at end of N+1; the read drives ram at N+2 and returns the new data (program order preserved).
- Arbitration in cycle N:
  - Only one requesting: it wins.
  - Both requesting: D wins unless starve_cnt == STARVE_LIMIT, then I wins.
  - At most one gnt per cycle; gnt is only asserted with the matching req.
- starve_cnt (4 bits):
  - Cleared on i_gnt or when i_req = 0.
  - Increments when i_req & ~i_gnt; saturates at STARVE_LIMIT.
- Idle cycle: no req, so issue-stage valid = 0; ram_we = 0; ram addresses hold their last value (don't-care).
- Response outputs: i_rdata/d_rdata hold their last value when not valid. The non-owner's rvalid is always 0.
- Reset (rst = 0 at a posedge):
  - Cleared: issue-stage valid, response valid, starve_cnt, i_rvalid, d_rvalid, ram_we; i_rdata and d_rdata = 0.
  - In-flight accesses are dropped: no rvalid ever issues for them. A write in the issue stage at the reset edge is suppressed (ram_we = 0 from that edge).
- While rst = 0: i_gnt = d_gnt = 0 regardless of requests.
- No FSM beyond the two valid bits. Owner encoding comes from the package constants.

Decomposition:
- Package mem_arb_pkg:
  - OWNER_I = 1'b0, OWNER_D = 1'b1.
  - Issue-stage record fields {valid, owner, we, addr, wdata} as a packed struct typedef, parameterised widths via localparams mirroring ADDRESS_WIDTH/WIDTH defaults.
- One sub-module: mem_arb_pick.
  - Purely combinational winner select from i_req, d_req and the starve flag.
  - Outputs i_gnt, d_gnt, owner.
- Starvation counter and both pipeline registers live in mem_port_arbiter.

Test Plan:
- Reset, then D read only:
  - d_req=1, d_we=0, d_addr=0x010, mem[4]=0xDEADBEEF.
  - d_gnt at N; ram_read_addr=0x010 at N+1; d_rvalid=1 and d_rdata=0xDEADBEEF at N+2; i_rvalid stays 0.
- D write then read back:
  - Write 0x12345678 to 0x020 at N, read 0x020 at N+1 (two consecutive grants).
  - ram_we=1 at N+1 only; write completion d_rvalid with d_rdata=0 at N+2; read d_rvalid with 0x12345678 at N+3.
- Contention, STARVE_LIMIT=4:
  - i_req and d_req both held high for 10 cycles; D re-requests each cycle.
  - Grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- Interleaved responses:
  - I at 0x000 (mem[0]=0x00000013) granted at N; D read at 0x004 (mem[1]=0x00A00093) granted at N+1.
  - i_rvalid with 0x00000013 at N+2; d_rvalid with 0x00A00093 at N+3; never both in one cycle.
- Reset mid-operation:
  - D write to 0x030 granted at N; rst=0 sampled at the N+1 edge.
  - ram_we=0 in cycle N+1; mem[12] unchanged; no d_rvalid for 3 cycles after reset release.
- Reset hold:
  - rst=0 with i_req=d_req=1 for 3 cycles.
  - i_gnt=d_gnt=0 throughout; the first grant after release goes to D.
